// File: rtl/servo_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// servo_sweep_ctrl : frame-synchronous servo PWM generator with sweep/centre moves
// Revision 1.0
// ============================================================================
module servo_sweep_ctrl #(
  parameter int PERIOD   = 2000000,
  parameter int DUTY_MIN = 100000,
  parameter int DUTY_MAX = 200000,
  parameter int DUTY_CTR = 150000,
  parameter int STEP     = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  servo_flag,
  output logic [18:0] s_duty,
  output logic        s_pulse,
  output logic        busy,
  output logic        done
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int VW = (CW > 20) ? CW : 20;

  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [19:0]   D_MIN    = 20'(DUTY_MIN);
  localparam logic [19:0]   D_MAX    = 20'(DUTY_MAX);
  localparam logic [19:0]   D_CTR    = 20'(DUTY_CTR);
  localparam logic [19:0]   D_STEP   = 20'(STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2,
    CTR  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [18:0]   duty_act;
  logic [18:0]   duty_nxt;
  logic          done_nxt;
  logic          frame_end;

  logic [19:0] duty_ext;
  logic [19:0] up_val;
  logic [19:0] dn_val;
  logic [19:0] ctr_val;

  assign frame_end = (cnt == CNT_LAST);
  assign busy      = (state != IDLE);

  // Candidate duties, clamped before any narrowing back to 19 bits.
  always_comb begin
    duty_ext = {1'b0, s_duty};
    up_val   = (duty_ext + D_STEP >= D_MAX) ? D_MAX : duty_ext + D_STEP;
    dn_val   = (duty_ext <= D_MIN + D_STEP) ? D_MIN : duty_ext - D_STEP;
    if (duty_ext < D_CTR) begin
      ctr_val = (duty_ext + D_STEP >= D_CTR) ? D_CTR : duty_ext + D_STEP;
    end else if (duty_ext > D_CTR) begin
      ctr_val = (duty_ext <= D_CTR + D_STEP) ? D_CTR : duty_ext - D_STEP;
    end else begin
      ctr_val = D_CTR;
    end
  end

  always_comb begin
    state_nxt = state;
    duty_nxt  = s_duty;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (servo_flag[0]) begin
          state_nxt = CTR;
        end else if (servo_flag[1]) begin
          state_nxt = UP;
        end else if (servo_flag[2]) begin
          state_nxt = DN;
        end
      end
      UP: begin
        if (frame_end) begin
          duty_nxt = up_val[18:0];
          if (up_val == D_MAX) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      DN: begin
        if (frame_end) begin
          duty_nxt = dn_val[18:0];
          if (dn_val == D_MIN) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      CTR: begin
        if (frame_end) begin
          duty_nxt = ctr_val[18:0];
          if (ctr_val == D_CTR) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // duty_act takes the pre-edge s_duty, so the PWM trails s_duty by one frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      s_duty   <= D_CTR[18:0];
      duty_act <= D_CTR[18:0];
      s_pulse  <= 1'b0;
      done     <= 1'b0;
    end else begin
      cnt     <= frame_end ? '0 : cnt + CW'(1);
      s_pulse <= (VW'(cnt) < VW'(duty_act));
      s_duty  <= duty_nxt;
      done    <= done_nxt;
      if (frame_end) begin
        duty_act <= s_duty;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_servo_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// tb_servo_sweep_ctrl : scoreboard bench for servo_sweep_ctrl (small frame)
// Revision 1.0
// ============================================================================
module tb_servo_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  servo_flag;
  logic [18:0] s_duty;
  logic        s_pulse;
  logic        busy;
  logic        done;

  servo_sweep_ctrl #(
    .PERIOD  (100),
    .DUTY_MIN(10),
    .DUTY_MAX(20),
    .DUTY_CTR(15),
    .STEP    (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .servo_flag(servo_flag),
    .s_duty    (s_duty),
    .s_pulse   (s_pulse),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int duty_q[$];
  int done_q[$];
  int cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s: got %0d with nothing expected (t=%0t)", name, act, $time);
  endtask

  // Edges since reset release; frame-end edges are the multiples of 100.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Monitor: duty changes, done pulses and PWM pulse widths.
  int   prev_duty = 15;
  int   snap      = 15;
  int   run       = 0;
  int   run_exp   = 15;
  logic prev_pulse = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_duty  = s_duty;
      snap       = 15;
      run        = 0;
      prev_pulse = 1'b0;
    end else begin
      if (s_duty != prev_duty) begin
        check("duty_edge_phase", cyc % 100, 0);
        if (duty_q.size() == 0) unexpected("duty_change", s_duty);
        else                    check("duty_value", s_duty, duty_q.pop_front());
        prev_duty = s_duty;
      end
      if (done) begin
        if (done_q.size() == 0) begin
          unexpected("done_pulse", s_duty);
        end else begin
          check("done_duty", s_duty, done_q.pop_front());
          check("done_busy", busy, 0);
          check("done_phase", cyc % 100, 0);
        end
      end
      if (s_pulse && !prev_pulse) begin
        check("pulse_start", cyc % 100, 1);
        run_exp = snap;
        run     = 0;
      end
      if (s_pulse) run++;
      if (!s_pulse && prev_pulse) check("pulse_width", run, run_exp);
      prev_pulse = s_pulse;
      if (cyc % 100 == 99) snap = s_duty;
    end
  end

  task automatic cmd(input logic [2:0] f);
    @(negedge clk);
    servo_flag = f;
    @(negedge clk);
    servo_flag = 3'b000;
    check("cmd_busy", busy, 1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", busy, 0);
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    servo_flag = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_duty", s_duty, 15);
    check("rst_pulse", s_pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;

    repeat (250) @(negedge clk);
    check("idle_duty", s_duty, 15);
    check("idle_busy", busy, 0);

    // Sweep up: 15 -> 18 -> 20
    duty_q.push_back(18); duty_q.push_back(20); done_q.push_back(20);
    cmd(3'b010);
    wait_idle(400);

    // Sweep down, with an up command pulsed mid-move that must be ignored
    duty_q.push_back(17); duty_q.push_back(14);
    duty_q.push_back(11); duty_q.push_back(10); done_q.push_back(10);
    cmd(3'b100);
    repeat (50) @(negedge clk);
    servo_flag = 3'b010;
    @(negedge clk);
    servo_flag = 3'b000;
    check("dn_busy", busy, 1);
    wait_idle(600);
    repeat (5) @(negedge clk);
    check("no_queued_cmd", busy, 0);
    check("dn_final_duty", s_duty, 10);

    // All flags set: centre wins, 10 -> 13 -> 15
    duty_q.push_back(13); duty_q.push_back(15); done_q.push_back(15);
    cmd(3'b111);
    wait_idle(400);

    // Centre while already centred: one frame busy, done, duty unchanged
    done_q.push_back(15);
    cmd(3'b001);
    wait_idle(200);
    check("ctr_hold_duty", s_duty, 15);

    // Reset in the middle of an up sweep
    duty_q.push_back(18);
    cmd(3'b010);
    n = 0;
    while (s_duty != 18 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_up_reached", s_duty, 18);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_duty", s_duty, 15);
    check("async_rst_pulse", s_pulse, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    repeat (250) @(negedge clk);
    check("post_rst_duty", s_duty, 15);
    check("post_rst_busy", busy, 0);
    check("duty_q_drained", duty_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
